// File: rtl/parity_pkg.sv
// Shared constants for the parity checker feeder: FSM state encoding,
// default byte width and bit-counter width.
package parity_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int BIT_CNT_W  = 4;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t SHIFT   = 3'd1;
  localparam state_t LAUNCH  = 3'd2;
  localparam state_t WAIT_HI = 3'd3;
  localparam state_t WAIT_LO = 3'd4;
  localparam state_t CAPTURE = 3'd5;

endpackage

// File: rtl/parity_sipo_shift.sv
// LSB-first serial-in/parallel-out register: each accepted bit enters at the
// MSB and the word shifts right, so after DATA_W shifts the first bit is bit 0.
module parity_sipo_shift
  import parity_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en_i,
  input  logic              clear_i,
  input  logic              bit_i,
  output logic [DATA_W-1:0] data_nxt_o,
  output logic              full_o,
  output logic              last_o
);

  logic [DATA_W-1:0]    data_q;
  logic [BIT_CNT_W-1:0] cnt_q;

  // data_nxt_o is the word as it will look after this shift, so the owner can
  // capture a complete byte on the same edge as the final bit.
  assign data_nxt_o = {bit_i, data_q[DATA_W-1:1]};
  assign full_o     = (cnt_q == BIT_CNT_W'(DATA_W));
  assign last_o     = shift_en_i && (cnt_q == BIT_CNT_W'(DATA_W - 1));

  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (clear_i) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (shift_en_i && !full_o) begin
      data_q <= data_nxt_o;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/parity_byte_loader.sv
// Feeder for the 8-bit parity checker: assembles a serial byte, pulses start,
// follows the busy handshake and registers the checker's verdict.
// Optional busy-handshake watchdog enabled by defining PARITY_TIMEOUT_EN.
module parity_byte_loader
  import parity_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = 64,
  parameter int TIMEOUT_W   = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ser_bit,
  input  logic              ser_valid,
  output logic              ser_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              start,
  input  logic              busy,
  input  logic              even_parity,
  input  logic              odd_parity,
  output logic              result_valid,
  output logic              result_odd,
  output logic [DATA_W-1:0] result_byte,
  output logic              overrun,
  output logic              timeout,
  input  logic              clr_sticky
);

  state_t            state_q, state_d;
  logic              accept;
  logic              sh_full, sh_last, sh_clear;
  logic [DATA_W-1:0] sh_data_nxt;
  logic              tmo_hit, tmo_fire;

  logic              start_q, result_valid_q, result_odd_q, overrun_q;
  logic [DATA_W-1:0] data_out_q, result_byte_q;

  assign ser_ready = ((state_q == IDLE) || (state_q == SHIFT)) && !sh_full;
  assign accept    = ser_valid && ser_ready;
  // The bit counter returns to zero whenever the FSM falls back into IDLE.
  assign sh_clear  = (state_d == IDLE) && (state_q != IDLE);

  parity_sipo_shift #(.DATA_W(DATA_W)) u_sipo (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en_i (accept),
    .clear_i    (sh_clear),
    .bit_i      (ser_bit),
    .data_nxt_o (sh_data_nxt),
    .full_o     (sh_full),
    .last_o     (sh_last)
  );

  // NOTE: every variable written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    tmo_fire = 1'b0;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (sh_last) state_d = LAUNCH;
      LAUNCH:  state_d = WAIT_HI;
      WAIT_HI: begin
        if (busy) begin
          state_d = WAIT_LO;
        end else if (tmo_hit) begin
          state_d  = IDLE;
          tmo_fire = 1'b1;
        end
      end
      WAIT_LO: begin
        if (!busy) begin
          state_d = CAPTURE;
        end else if (tmo_hit) begin
          state_d  = IDLE;
          tmo_fire = 1'b1;
        end
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef PARITY_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt_q;
  logic                 timeout_q;

  // Restarts on every state change, so WAIT_HI and WAIT_LO each get a full budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_d != state_q) begin
        tmo_cnt_q <= '0;
      end else if (((state_q == WAIT_HI) || (state_q == WAIT_LO)) && (tmo_cnt_q != '1)) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
      timeout_q <= tmo_fire || (timeout_q && !clr_sticky);
    end
  end

  assign tmo_hit = (tmo_cnt_q == TIMEOUT_W'(TIMEOUT_CYC));
  assign timeout = timeout_q;
`else
  logic unused_tmo;
  assign tmo_hit    = 1'b0;
  assign timeout    = 1'b0;
  assign unused_tmo = (TIMEOUT_CYC > 0) && (TIMEOUT_W > 0) && tmo_fire;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      start_q        <= 1'b0;
      result_valid_q <= 1'b0;
      result_odd_q   <= 1'b0;
      overrun_q      <= 1'b0;
      data_out_q     <= '0;
      result_byte_q  <= '0;
    end else begin
      state_q        <= state_d;
      start_q        <= (state_d == LAUNCH);
      result_valid_q <= (state_q == CAPTURE);
      if (state_q == SHIFT && sh_last) begin
        data_out_q <= sh_data_nxt;
      end
      if (state_q == CAPTURE) begin
        result_odd_q  <= odd_parity;
        result_byte_q <= data_out_q;
      end
      // A refused bit in the same cycle as a clear keeps the flag set.
      overrun_q <= (ser_valid && !ser_ready) || (overrun_q && !clr_sticky);
    end
  end

  // A checker fault (even_parity == odd_parity) is not flagged here;
  // result_odd follows odd_parity unconditionally.
  logic unused_even;
  assign unused_even = even_parity;

  assign start        = start_q;
  assign data_out     = data_out_q;
  assign result_valid = result_valid_q;
  assign result_odd   = result_odd_q;
  assign result_byte  = result_byte_q;
  assign overrun      = overrun_q;

endmodule
